// File: rtl/dpram_port_arbiter.sv
// ============================================================================
// Module   : dpram_port_arbiter
// Purpose  : Round-robin, burst-limited arbiter sharing one dpram port
//            between two single-word read/write requesters.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dpram_port_arbiter #(
    parameter int AWIDTH    = 10,
    parameter int DWIDTH    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              req0,
    input  logic              we0,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [DWIDTH-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DWIDTH-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DWIDTH-1:0] rdata1,

    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_q
);

    localparam int              CW          = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0]   c_BURST_MAX = CW'(BURST_MAX);
    localparam logic [CW-1:0]   c_CNT_ONE   = CW'(1);

    typedef enum logic {
        ID_R0 = 1'b0,
        ID_R1 = 1'b1
    } req_id_t;

    // Arbitration state
    req_id_t           last_q, last_d;
    logic [CW-1:0]     cnt_q,  cnt_d;

    // Command register driving the RAM port
    logic [AWIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_wren_q,  mem_wren_d;

    // Read response pipeline
    logic              s1_valid_q, s1_valid_d;
    req_id_t           s1_id_q,    s1_id_d;
    logic              s2_valid_q;
    req_id_t           s2_id_q;

    // Grant decision
    logic              w_gnt_valid;
    req_id_t           w_gnt_id;
    logic              w_sel_we;
    logic [AWIDTH-1:0] w_sel_addr;
    logic [DWIDTH-1:0] w_sel_wdata;
    logic              w_in_burst;

    // Keep granting `last` only while a burst is running and not yet exhausted.
    assign w_in_burst = (cnt_q != '0) && (cnt_q < c_BURST_MAX);

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = ID_R0;
        if (resetn) begin
            case ({req1, req0})
                2'b01: begin
                    w_gnt_valid = 1'b1;
                    w_gnt_id    = ID_R0;
                end
                2'b10: begin
                    w_gnt_valid = 1'b1;
                    w_gnt_id    = ID_R1;
                end
                2'b11: begin
                    w_gnt_valid = 1'b1;
                    if (w_in_burst) begin
                        w_gnt_id = last_q;
                    end else begin
                        w_gnt_id = (last_q == ID_R0) ? ID_R1 : ID_R0;
                    end
                end
                default: begin
                    w_gnt_valid = 1'b0;
                end
            endcase
        end
    end

    assign gnt0 = w_gnt_valid && (w_gnt_id == ID_R0);
    assign gnt1 = w_gnt_valid && (w_gnt_id == ID_R1);

    assign w_sel_we    = (w_gnt_id == ID_R1) ? we1    : we0;
    assign w_sel_addr  = (w_gnt_id == ID_R1) ? addr1  : addr0;
    assign w_sel_wdata = (w_gnt_id == ID_R1) ? wdata1 : wdata0;

    always_comb begin
        last_d = last_q;
        cnt_d  = cnt_q;
        if (!w_gnt_valid) begin
            cnt_d = '0;
        end else if ((w_gnt_id == last_q) && (cnt_q != '0)) begin
            if (cnt_q < c_BURST_MAX) begin
                cnt_d = cnt_q + c_CNT_ONE;
            end
        end else begin
            cnt_d  = c_CNT_ONE;
            last_d = w_gnt_id;
        end
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren_d  = 1'b0;
        s1_valid_d  = 1'b0;
        s1_id_d     = w_gnt_id;
        if (w_gnt_valid) begin
            mem_addr_d  = w_sel_addr;
            mem_wdata_d = w_sel_wdata;
            mem_wren_d  = w_sel_we;
            s1_valid_d  = !w_sel_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_q      <= ID_R1;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= ID_R0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= ID_R0;
        end else begin
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s2_valid_q  <= s1_valid_q;
            s2_id_q     <= s1_id_q;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;

    // Gated by resetn so a read granted before reset can never surface.
    assign rvalid0 = resetn && s2_valid_q && (s2_id_q == ID_R0);
    assign rvalid1 = resetn && s2_valid_q && (s2_id_q == ID_R1);
    assign rdata0  = mem_q;
    assign rdata1  = mem_q;

endmodule

`default_nettype wire

// File: tb/tb_dpram_port_arbiter.sv
// ============================================================================
// Module   : tb_dpram_port_arbiter
// Purpose  : Self-checking bench for dpram_port_arbiter (BURST_MAX 4 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dpram_port_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int NI    = 2;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    logic [1:0]    gnt0_o, gnt1_o, rv0_o, rv1_o, mwren_o;
    logic [AW-1:0] maddr_o [NI];
    logic [DW-1:0] mwdata_o[NI];
    logic [DW-1:0] rd0_o   [NI];
    logic [DW-1:0] rd1_o   [NI];
    logic [DW-1:0] mq      [NI];
    logic [DW-1:0] ram     [NI][DEPTH];
    logic          ram_clr;

    dpram_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .BURST_MAX(4)) u_dut4 (
        .clk(clk), .resetn(resetn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0_o[0]), .rvalid0(rv0_o[0]), .rdata0(rd0_o[0]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1_o[0]), .rvalid1(rv1_o[0]), .rdata1(rd1_o[0]),
        .mem_addr(maddr_o[0]), .mem_wren(mwren_o[0]), .mem_wdata(mwdata_o[0]),
        .mem_q(mq[0])
    );

    dpram_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .BURST_MAX(1)) u_dut1 (
        .clk(clk), .resetn(resetn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0_o[1]), .rvalid0(rv0_o[1]), .rdata0(rd0_o[1]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1_o[1]), .rvalid1(rv1_o[1]), .rdata1(rd1_o[1]),
        .mem_addr(maddr_o[1]), .mem_wren(mwren_o[1]), .mem_wdata(mwdata_o[1]),
        .mem_q(mq[1])
    );

    // Registered-output RAM behind each arbiter, one cycle read latency.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (ram_clr) begin
                for (int a = 0; a < DEPTH; a++) ram[k][a] <= '0;
                mq[k] <= '0;
            end else begin
                if (mwren_o[k]) ram[k][maddr_o[k][2:0]] <= mwdata_o[k];
                mq[k] <= ram[k][maddr_o[k][2:0]];
            end
        end
    end

    // Reference model: grant rules, shadow memory, scheduled responses.
    typedef struct packed {
        int            inst;
        int            due;
        int            id;
        logic [DW-1:0] data;
    } resp_t;

    resp_t         pend[$];
    int            m_last [NI];
    int            m_cnt  [NI];
    int            burst  [NI];
    logic          exp_wren [NI];
    logic [AW-1:0] exp_addr [NI];
    logic [DW-1:0] exp_wdata[NI];
    logic [DW-1:0] shadow[NI][DEPTH];
    int            obs_g[NI];
    int            cyc;
    int            n_checks;
    int            n_errors;

    function automatic int model_grant(input int k, input logic rn, input logic r0, input logic r1);
        if (!rn || (!r0 && !r1)) return -1;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (m_cnt[k] > 0 && m_cnt[k] < burst[k]) return m_last[k];
        return 1 - m_last[k];
    endfunction

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s inst=%0d cyc=%0d observed=%0h expected=%0h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic cycle(input logic rn,
                         input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        resp_t keep[$];
        @(negedge clk);
        resetn = rn;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #1;
        for (int k = 0; k < NI; k++) begin
            int            g;
            logic          ev0, ev1, sw;
            logic [DW-1:0] ed, sd;
            logic [AW-1:0] sa;
            resp_t         r;
            g = model_grant(k, rn, r0, r1);
            obs_g[k] = gnt0_o[k] ? (gnt1_o[k] ? 2 : 0) : (gnt1_o[k] ? 1 : -1);
            chk("gnt0", k, 64'(gnt0_o[k]), 64'(g == 0));
            chk("gnt1", k, 64'(gnt1_o[k]), 64'(g == 1));
            chk("mem_wren", k, 64'(mwren_o[k]), 64'(exp_wren[k]));
            chk("mem_addr", k, 64'(maddr_o[k]), 64'(exp_addr[k]));
            chk("mem_wdata", k, 64'(mwdata_o[k]), 64'(exp_wdata[k]));
            ev0 = 1'b0; ev1 = 1'b0; ed = '0;
            if (rn) begin
                foreach (pend[i]) begin
                    if (pend[i].inst == k && pend[i].due == cyc) begin
                        if (pend[i].id == 0) ev0 = 1'b1; else ev1 = 1'b1;
                        ed = pend[i].data;
                    end
                end
            end
            chk("rvalid0", k, 64'(rv0_o[k]), 64'(ev0));
            chk("rvalid1", k, 64'(rv1_o[k]), 64'(ev1));
            if (ev0) chk("rdata0", k, 64'(rd0_o[k]), 64'(ed));
            if (ev1) chk("rdata1", k, 64'(rd1_o[k]), 64'(ed));

            if (!rn) begin
                m_last[k] = 1; m_cnt[k] = 0;
                exp_wren[k] = 1'b0; exp_addr[k] = '0; exp_wdata[k] = '0;
            end else if (g < 0) begin
                m_cnt[k] = 0;
                exp_wren[k] = 1'b0;
            end else begin
                sw = (g == 1) ? w1 : w0;
                sa = (g == 1) ? a1 : a0;
                sd = (g == 1) ? d1 : d0;
                if (g == m_last[k] && m_cnt[k] != 0) begin
                    if (m_cnt[k] < burst[k]) m_cnt[k]++;
                end else begin
                    m_cnt[k] = 1; m_last[k] = g;
                end
                exp_wren[k] = sw; exp_addr[k] = sa; exp_wdata[k] = sd;
                if (sw) begin
                    shadow[k][sa[2:0]] = sd;
                end else begin
                    r.inst = k; r.due = cyc + 2; r.id = g; r.data = shadow[k][sa[2:0]];
                    pend.push_back(r);
                end
            end
        end
        if (!rn) begin
            pend.delete();
        end else begin
            foreach (pend[i]) if (pend[i].due > cyc) keep.push_back(pend[i]);
            pend = keep;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic          rr, q0, q1, w0, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        n_checks = 0; n_errors = 0; cyc = 0;
        burst[0] = 4; burst[1] = 1;
        for (int k = 0; k < NI; k++) begin
            m_last[k] = 1; m_cnt[k] = 0;
            exp_wren[k] = 1'b0; exp_addr[k] = '0; exp_wdata[k] = '0;
            for (int a = 0; a < DEPTH; a++) shadow[k][a] = '0;
        end
        resetn = 1'b0; ram_clr = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        @(posedge clk);
        #1 ram_clr = 1'b0;

        // Reset held with both requesting: nothing granted, outputs at reset values.
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 10'd1, '0, 1'b1, 1'b0, 10'd2, '0);

        // First contention after release goes to r0.
        cycle(1'b1, 1'b1, 1'b0, 10'd1, '0, 1'b1, 1'b0, 10'd2, '0);
        chk("first_grant", 0, 64'(obs_g[0]), 64'(0));
        chk("first_grant", 1, 64'(obs_g[1]), 64'(0));

        // r0 writes then reads the same word.
        cycle(1'b1, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b1, 1'b0, 10'd5, '0, 1'b0, 1'b0, '0, '0);
        chk("wr_on_port", 0, 64'({mwren_o[0], maddr_o[0]}), 64'({1'b1, 10'd5}));
        idle(2);
        chk("rd_back", 0, 64'({rv0_o[0], rd0_o[0]}), 64'({1'b1, 32'hDEADBEEF}));
        idle(2);

        // Continuous contention from reset.
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, 1'b0, AW'(i % 8), '0, 1'b1, 1'b0, AW'((i + 3) % 8), '0);
            chk("pattern_b4", 0, 64'(obs_g[0]), 64'((i / 4) % 2));
            chk("pattern_b1", 1, 64'(obs_g[1]), 64'(i % 2));
        end
        idle(3);

        // An idle cycle ends the burst: r0 wins the next contention.
        repeat (3) cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd4, '0);
        idle(1);
        cycle(1'b1, 1'b1, 1'b0, 10'd1, '0, 1'b1, 1'b0, 10'd2, '0);
        chk("idle_clears", 0, 64'(obs_g[0]), 64'(0));
        chk("idle_clears", 1, 64'(obs_g[1]), 64'(0));
        idle(3);

        // Reset right after a read grant drops the response.
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd3, '0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        idle(1);
        chk("drop_rvalid1", 0, 64'(rv1_o[0]), 64'(0));
        chk("drop_rvalid1", 1, 64'(rv1_o[1]), 64'(0));
        idle(2);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 800; i++) begin
            rr = ($urandom_range(0, 39) != 0);
            q0 = ($urandom_range(0, 3) != 0);
            q1 = ($urandom_range(0, 3) != 0);
            w0 = ($urandom_range(0, 2) == 0);
            w1 = ($urandom_range(0, 2) == 0);
            a0 = AW'($urandom_range(0, 7));
            a1 = AW'($urandom_range(0, 7));
            d0 = $urandom;
            d1 = $urandom;
            cycle(rr, q0, w0, a0, d0, q1, w1, a1, d1);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
